// File: rtl/decode_stage.sv
// LC3 decode stage: registers the fetched instruction and next-PC, and produces execute/writeback/memory control words.
// Optional unsupported-opcode detection is built when DECODE_ILLEGAL_DETECT_EN is defined.
module decode_stage #(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decode,
  input  logic        flush,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        dec_valid,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  localparam logic [5:0] E_BR = 6'b000110;

  // Packed as {E_Control, W_Control, Mem_Control}; unsupported opcodes fall to all-zero.
  function automatic logic [8:0] decode_ctrl(input logic [3:0] op, input logic imm);
    logic [8:0] c;
    c = 9'd0;
    case (op)
      4'b0001: c = imm ? {6'b001100, 2'b00, 1'b0} : {6'b001101, 2'b00, 1'b0};
      4'b0101: c = imm ? {6'b011100, 2'b00, 1'b0} : {6'b011101, 2'b00, 1'b0};
      4'b1001: c = {6'b101100, 2'b00, 1'b0};
      4'b0000: c = {E_BR, 2'b00, 1'b0};
      4'b0010: c = {E_BR, 2'b01, 1'b0};
      4'b1010: c = {E_BR, 2'b01, 1'b1};
      4'b1110: c = {E_BR, 2'b10, 1'b0};
      4'b0011: c = {E_BR, 2'b00, 1'b0};
      4'b1011: c = {E_BR, 2'b00, 1'b1};
      4'b0110: c = {6'b001000, 2'b01, 1'b0};
      4'b0111: c = {6'b001000, 2'b00, 1'b0};
      4'b1100: c = {6'b001100, 2'b00, 1'b0};
      default: c = 9'd0;
    endcase
    return c;
  endfunction

  logic [15:0] ir_p1;
  logic [15:0] npc_p1;
  logic [5:0]  e_p1;
  logic [1:0]  w_p1;
  logic        m_p1;
  logic        vld_p1;
  logic [8:0]  ctrl_p0;

  assign ctrl_p0 = decode_ctrl(dout[15:12], dout[5]);

  // p0 -> p1: capture/flush register; idle cycles hold so an undriven dout never enters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_p1  <= RESET_IR;
      npc_p1 <= 16'h0000;
      e_p1   <= 6'd0;
      w_p1   <= 2'd0;
      m_p1   <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      ir_p1  <= RESET_IR;
      e_p1   <= E_BR;
      w_p1   <= 2'b00;
      m_p1   <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (enable_decode) begin
      ir_p1  <= dout;
      npc_p1 <= npc_in;
      e_p1   <= ctrl_p0[8:3];
      w_p1   <= ctrl_p0[2:1];
      m_p1   <= ctrl_p0[0];
      vld_p1 <= 1'b1;
    end
  end

  assign IR          = ir_p1;
  assign npc_out     = npc_p1;
  assign E_Control   = e_p1;
  assign W_Control   = w_p1;
  assign Mem_Control = m_p1;
  assign dec_valid   = vld_p1;

`ifdef DECODE_ILLEGAL_DETECT_EN
  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b1000) || (op == 4'b1101) || (op == 4'b1111);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic       illegal_p1;
  logic [7:0] illegal_cnt_p1;

  // p0 -> p1: illegal flag follows captures/flushes; the count only ever clears on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_p1     <= 1'b0;
      illegal_cnt_p1 <= 8'h00;
    end else if (flush) begin
      illegal_p1 <= 1'b0;
    end else if (enable_decode) begin
      illegal_p1 <= is_illegal(dout[15:12]);
      if (is_illegal(dout[15:12]))
        illegal_cnt_p1 <= sat_inc(illegal_cnt_p1);
    end
  end

  assign illegal       = illegal_p1;
  assign illegal_count = illegal_cnt_p1;
`else
  assign illegal       = 1'b0;
  assign illegal_count = 8'h00;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; illegal-opcode expectations follow DECODE_ILLEGAL_DETECT_EN.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable_decode;
  logic        flush;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        dec_valid;
  logic        illegal;
  logic [7:0]  illegal_count;

  int checks = 0;
  int failures = 0;

  decode_stage #(.RESET_IR(16'h0000)) dut (
    .clk(clk), .rst(rst), .enable_decode(enable_decode), .flush(flush),
    .dout(dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
    .E_Control(E_Control), .W_Control(W_Control), .Mem_Control(Mem_Control),
    .dec_valid(dec_valid), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_DETECT_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  // Inputs applied here land on the next rising edge; outputs are sampled 1ns after it.
  task automatic cap(input logic [15:0] w, input logic [15:0] npc);
    enable_decode = 1'b1; flush = 1'b0; dout = w; npc_in = npc;
    @(posedge clk); #1;
    enable_decode = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable_decode = 1'b0; flush = 1'b0; dout = 16'h0000; npc_in = 16'h0000;
    #3;
    checks++; if (IR !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", IR); end
    checks++; if (npc_out !== 16'h0000) begin failures++; $display("FAIL reset_npc got=%h exp=0000", npc_out); end
    checks++; if ({E_Control, W_Control, Mem_Control} !== 9'd0) begin failures++; $display("FAIL reset_ctrl got=%b_%b_%b exp=0", E_Control, W_Control, Mem_Control); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    checks++; if ({illegal, illegal_count} !== 9'd0) begin failures++; $display("FAIL reset_illegal got=%b/%h exp=0/00", illegal, illegal_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL idle_after_reset valid got=%b exp=0", dec_valid); end
  endtask

  task automatic test_add;
    cap(16'h1283, 16'h3001);
    checks++; if (IR !== 16'h1283) begin failures++; $display("FAIL add_ir got=%h exp=1283", IR); end
    checks++; if (npc_out !== 16'h3001) begin failures++; $display("FAIL add_npc got=%h exp=3001", npc_out); end
    checks++; if ({E_Control, W_Control, Mem_Control} !== {6'b001101, 2'b00, 1'b0}) begin failures++; $display("FAIL add_ctrl got=%b_%b_%b exp=001101_00_0", E_Control, W_Control, Mem_Control); end
    checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", dec_valid); end
  endtask

  task automatic test_opcodes;
    logic [15:0] words [6]  = '{16'h1261, 16'h5020, 16'h5283, 16'h927F, 16'hE005, 16'hC1C0};
    logic [8:0]  expct [6]  = '{{6'b001100, 2'b00, 1'b0}, {6'b011100, 2'b00, 1'b0},
                                {6'b011101, 2'b00, 1'b0}, {6'b101100, 2'b00, 1'b0},
                                {6'b000110, 2'b10, 1'b0}, {6'b001100, 2'b00, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      cap(words[i], 16'h3100 + 16'(i));
      checks++;
      if ({E_Control, W_Control, Mem_Control} !== expct[i]) begin
        failures++; $display("FAIL opcode_ctrl word=%h got=%b_%b_%b exp=%b", words[i], E_Control, W_Control, Mem_Control, expct[i]);
      end
    end
    // JSR is unsupported: captured as-is with zero control
    cap(16'h4801, 16'h3200);
    checks++; if ({IR, E_Control, W_Control, Mem_Control, dec_valid} !== {16'h4801, 9'd0, 1'b1}) begin failures++; $display("FAIL jsr got=%h_%b_%b_%b_%b exp=4801_0_0_0_1", IR, E_Control, W_Control, Mem_Control, dec_valid); end
    checks++; if (illegal !== DET) begin failures++; $display("FAIL jsr_illegal got=%b exp=%b", illegal, DET); end
  endtask

  task automatic test_back_to_back;
    enable_decode = 1'b1; flush = 1'b0; dout = 16'hA405; npc_in = 16'h3010;
    @(posedge clk); #1;
    dout = 16'h7281; npc_in = 16'h3011;
    checks++; if ({E_Control, W_Control, Mem_Control} !== {6'b000110, 2'b01, 1'b1}) begin failures++; $display("FAIL ldi_ctrl got=%b_%b_%b exp=000110_01_1", E_Control, W_Control, Mem_Control); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ldi_illegal got=%b exp=0", illegal); end
    @(posedge clk); #1;
    enable_decode = 1'b0;
    checks++; if ({E_Control, W_Control, Mem_Control} !== {6'b001000, 2'b00, 1'b0}) begin failures++; $display("FAIL str_ctrl got=%b_%b_%b exp=001000_00_0", E_Control, W_Control, Mem_Control); end
    checks++; if ({IR, npc_out} !== {16'h7281, 16'h3011}) begin failures++; $display("FAIL str_ir_npc got=%h/%h exp=7281/3011", IR, npc_out); end
  endtask

  task automatic test_hold_x;
    enable_decode = 1'b0; flush = 1'b0; dout = 16'hxxxx; npc_in = 16'hxxxx;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ($isunknown({IR, npc_out, E_Control, W_Control, Mem_Control, dec_valid, illegal, illegal_count})) begin
        failures++; $display("FAIL hold_x cycle=%0d got ir=%h ctrl=%b_%b_%b exp=no X", i, IR, E_Control, W_Control, Mem_Control);
      end
      checks++;
      if ({IR, npc_out, E_Control, W_Control, Mem_Control, dec_valid} !== {16'h7281, 16'h3011, 6'b001000, 2'b00, 1'b0, 1'b1}) begin
        failures++; $display("FAIL hold_val cycle=%0d got=%h/%h/%b exp=7281/3011/001000", i, IR, npc_out, E_Control);
      end
    end
  endtask

  task automatic test_flush;
    enable_decode = 1'b1; flush = 1'b1; dout = 16'h5020; npc_in = 16'h4444;
    @(posedge clk); #1;
    enable_decode = 1'b0; flush = 1'b0;
    checks++; if (IR !== 16'h0000) begin failures++; $display("FAIL flush_ir got=%h exp=0000", IR); end
    checks++; if ({E_Control, W_Control, Mem_Control} !== {6'b000110, 2'b00, 1'b0}) begin failures++; $display("FAIL flush_ctrl got=%b_%b_%b exp=000110_00_0", E_Control, W_Control, Mem_Control); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", dec_valid); end
    checks++; if (npc_out !== 16'h3011) begin failures++; $display("FAIL flush_npc got=%h exp=3011", npc_out); end
  endtask

  task automatic test_illegal;
    for (int i = 1; i <= 257; i++) begin
      cap(16'hF025, 16'h5000 + 16'(i));
      if (i == 1) begin
        checks++; if ({IR, E_Control, W_Control, Mem_Control, dec_valid} !== {16'hF025, 9'd0, 1'b1}) begin failures++; $display("FAIL trap_capture got=%h_%b_%b_%b_%b exp=F025_0_0_0_1", IR, E_Control, W_Control, Mem_Control, dec_valid); end
        checks++; if ({illegal, illegal_count} !== (DET ? 9'h101 : 9'h000)) begin failures++; $display("FAIL trap_first got=%b/%h exp=%b/%h", illegal, illegal_count, DET, DET ? 8'h01 : 8'h00); end
      end
      if (i == 254 || i == 255 || i == 257) begin
        checks++;
        if (illegal_count !== (DET ? ((i == 254) ? 8'hFE : 8'hFF) : 8'h00)) begin
          failures++; $display("FAIL trap_count n=%0d got=%h exp=%h", i, illegal_count, DET ? ((i == 254) ? 8'hFE : 8'hFF) : 8'h00);
        end
      end
    end
    checks++; if (illegal !== DET) begin failures++; $display("FAIL trap_illegal got=%b exp=%b", illegal, DET); end
    cap(16'h1283, 16'h6000);
    checks++; if ({illegal, illegal_count} !== (DET ? 9'h0FF : 9'h000)) begin failures++; $display("FAIL add_after_trap got=%b/%h exp=0/%h", illegal, illegal_count, DET ? 8'hFF : 8'h00); end
    cap(16'hF025, 16'h6001);
    enable_decode = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({illegal, illegal_count} !== (DET ? 9'h0FF : 9'h000)) begin failures++; $display("FAIL flush_keeps_count got=%b/%h exp=0/%h", illegal, illegal_count, DET ? 8'hFF : 8'h00); end
  endtask

  task automatic test_reset_mid;
    cap(16'h2A07, 16'h7777);
    checks++; if ({W_Control, dec_valid} !== 3'b011) begin failures++; $display("FAIL ld_before_reset got=%b_%b exp=01_1", W_Control, dec_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({IR, npc_out} !== 32'h0) begin failures++; $display("FAIL midreset_ir_npc got=%h/%h exp=0000/0000", IR, npc_out); end
    checks++; if ({E_Control, W_Control, Mem_Control, dec_valid} !== 10'd0) begin failures++; $display("FAIL midreset_ctrl got=%b_%b_%b_%b exp=0", E_Control, W_Control, Mem_Control, dec_valid); end
    checks++; if ({illegal, illegal_count} !== 9'd0) begin failures++; $display("FAIL midreset_illegal got=%b/%h exp=0/00", illegal, illegal_count); end
    // Capture requested while reset is still low must be ignored
    enable_decode = 1'b1; dout = 16'h1283; npc_in = 16'h1111;
    @(posedge clk); #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL capture_in_reset got=%b exp=0", dec_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    enable_decode = 1'b0;
    checks++; if ({IR, npc_out, dec_valid} !== {16'h1283, 16'h1111, 1'b1}) begin failures++; $display("FAIL first_after_reset got=%h/%h/%b exp=1283/1111/1", IR, npc_out, dec_valid); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_opcodes;
    test_back_to_back;
    test_hold_x;
    test_flush;
    test_illegal;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
